program_loader: RTL and testbench

//  Byte-stream boot loader that sits directly upstream of the FRANK6000 CPU.

---
 rtl/program_loader_if.sv | 23 ++
 rtl/program_loader.sv | 68 ++++++
 tb/tb_program_loader.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// program_loader_if: byte stream in, CPU instruction-memory write port and status out
interface program_loader_if;
  logic        start;
  logic [7:0]  data;
  logic        valid;
  logic        ready;
  logic        loopf;
  logic [15:0] instr;
  logic [7:0]  instr_addr;
  logic        we;
  logic        on;
  logic        busy;
  logic        halted;
  logic        err;
  modport master (
    output start, data, valid, loopf,
    input  ready, instr, instr_addr, we, on, busy, halted, err
  );
  modport slave (
    input  start, data, valid, loopf,
    output ready, instr, instr_addr, we, on, busy, halted, err
  );
endinterface

// File: rtl/program_loader.sv
// program_loader: length-prefixed byte-stream boot loader feeding CPU instruction memory, then runs it
module program_loader #(
  parameter int TIMEOUT = 1000
) (
  input logic             clk,
  input logic             rst,
  program_loader_if.slave b
);
  localparam int GW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, HDR, HI, LO, WRITE, RUN, HALT} state_t;
  state_t state, next;
  logic [8:0] count;
  logic [7:0] addr;
  logic [15:0] instr;
  logic [GW-1:0] gap;
  logic err;
  logic xfer, body, to, last;
  assign b.ready = state == HDR || state == HI || state == LO;
  assign b.we = state == WRITE;
  assign b.on = state == RUN || state == HALT;
  assign b.busy = b.ready || b.we;
  assign b.halted = state == HALT;
  assign b.err = err;
  assign b.instr = instr;
  assign b.instr_addr = addr;
  assign xfer = b.valid && b.ready;
  assign body = state == HI || state == LO;
  assign to = body && !xfer && gap == GW'(TIMEOUT - 1);
  assign last = {1'b0, addr} == count - 9'd1;
  // Next-state decode; a stalled body aborts to IDLE, start wins over loopf in RUN
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = b.start ? HDR : IDLE;
      HDR:     next = xfer ? HI : HDR;
      HI:      next = xfer ? LO : to ? IDLE : HI;
      LO:      next = xfer ? WRITE : to ? IDLE : LO;
      WRITE:   next = last ? RUN : HI;
      RUN:     next = b.start ? HDR : b.loopf ? HALT : RUN;
      HALT:    next = b.start ? HDR : HALT;
      default: next = IDLE;
    endcase
  end
  // State register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next;
  // Datapath: count/address, instruction assembly, idle-gap counter and sticky error
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      count <= '0;
      addr <= '0;
      instr <= '0;
      gap <= '0;
      err <= 1'b0;
    end else begin
      if (state == HDR && xfer) begin
        count <= b.data == 8'd0 ? 9'd256 : {1'b0, b.data};
        addr <= '0;
      end
      if (state == HI && xfer) instr[15:8] <= b.data;
      if (state == LO && xfer) instr[7:0] <= b.data;
      if (state == WRITE && !last) addr <= addr + 8'd1;
      gap <= body && !xfer && next == state ? gap + GW'(1) : '0;
      if (state == IDLE && b.start) err <= 1'b0;
      else if (to) err <= 1'b1;
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: random program loads checked against a queue-based write model
module tb_program_loader;
  localparam int TO = 20;
  logic clk = 1'b0;
  logic rst;
  int tests = 0;
  int fails = 0;
  logic [15:0] prog[$];
  logic [23:0] exp_q[$];
  program_loader_if bif ();
  program_loader #(.TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .b(bif));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // every write strobe must match the next expected {addr, instr} and never coincide with run
  always @(negedge clk)
    if (bif.we === 1'b1) begin
      if (exp_q.size() == 0) check("extra_we", 1, 0);
      else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        check("wr_addr", bif.instr_addr, e[23:16]);
        check("wr_instr", bif.instr, e[15:0]);
      end
      check("we_vs_on", bif.on, 0);
    end

  task automatic pulse_start();
    bif.start = 1'b1;
    @(negedge clk);
    bif.start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    bif.data = d;
    bif.valid = 1'b1;
    n = 0;
    while (!bif.ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bif.ready) check("ready_wait", 0, 1);
    @(negedge clk);
    bif.valid = 1'b0;
  endtask

  task automatic load(input bit do_start, input int maxg);
    if (do_start) pulse_start();
    for (int i = 0; i < prog.size(); i++) exp_q.push_back({8'(i), prog[i]});
    send(8'(prog.size()), 0);
    foreach (prog[i]) begin
      send(prog[i][15:8], $urandom_range(0, maxg));
      send(prog[i][7:0], $urandom_range(0, maxg));
    end
    check("we_last", bif.we, 1);
    @(negedge clk);
    check("on_after_load", bif.on, 1);
    check("busy_in_run", bif.busy, 0);
    check("all_written", exp_q.size(), 0);
    check("no_err", bif.err, 0);
  endtask

  task automatic rand_prog(input int n);
    prog.delete();
    repeat (n) prog.push_back(16'($urandom));
  endtask

  initial begin
    int cnt;
    rst = 1'b1;
    bif.start = 1'b0;
    bif.valid = 1'b0;
    bif.data = 8'h00;
    bif.loopf = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", bif.ready, 0);
    check("rst_we", bif.we, 0);
    check("rst_on", bif.on, 0);
    check("rst_busy", bif.busy, 0);
    check("rst_halted", bif.halted, 0);
    check("rst_err", bif.err, 0);
    check("rst_addr", bif.instr_addr, 0);
    check("rst_instr", bif.instr, 0);
    rst = 1'b0;
    @(negedge clk);
    // basic two-instruction program
    prog = '{16'h1234, 16'h5678};
    load(1, 0);
    // stray bytes in RUN are not taken
    bif.valid = 1'b1;
    check("run_not_ready", bif.ready, 0);
    @(negedge clk);
    bif.valid = 1'b0;
    // loopf halts, start reloads
    bif.loopf = 1'b1;
    @(negedge clk);
    bif.loopf = 1'b0;
    check("halted", bif.halted, 1);
    check("halt_on", bif.on, 1);
    pulse_start();
    check("reload_on", bif.on, 0);
    check("reload_busy", bif.busy, 1);
    check("reload_hdr", bif.ready, 1);
    check("reload_halted", bif.halted, 0);
    // full 256-instruction image with count byte 0
    rand_prog(256);
    load(0, 0);
    check("last_addr", bif.instr_addr, 8'hFF);
    // timeout in the body
    pulse_start();
    exp_q.push_back({8'h00, 16'hAABB});
    send(8'h03, 0);
    send(8'hAA, 0);
    send(8'hBB, 0);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!bif.err && cnt < 5 * TO);
    check("timeout_cycles", cnt, TO + 1);
    check("timeout_err", bif.err, 1);
    check("timeout_on", bif.on, 0);
    check("timeout_busy", bif.busy, 0);
    check("timeout_written", exp_q.size(), 0);
    pulse_start();
    check("err_cleared", bif.err, 0);
    // random programs with idle gaps below the timeout
    repeat (4) begin
      rand_prog($urandom_range(1, 12));
      load(0, TO - 2);
      pulse_start();
    end
    // reset during WRITE
    exp_q.push_back({8'h00, 16'h1234});
    send(8'h01, 0);
    send(8'h12, 0);
    send(8'h34, 0);
    check("pre_rst_we", bif.we, 1);
    #1 rst = 1'b1;
    #1;
    check("async_we", bif.we, 0);
    check("async_busy", bif.busy, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    // start during HI is ignored
    pulse_start();
    exp_q.push_back({8'h00, 16'h1122});
    exp_q.push_back({8'h01, 16'h3344});
    send(8'h02, 0);
    pulse_start();
    check("hi_start_busy", bif.ready, 1);
    send(8'h11, 0);
    send(8'h22, 0);
    send(8'h33, 0);
    send(8'h44, 0);
    check("hi_we_last", bif.we, 1);
    @(negedge clk);
    check("hi_on", bif.on, 1);
    check("hi_written", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
